dircc_packet_send_arbiter: RTL and testbench

DIRCC_PACKET_SEND_ARBITER -- requirements
Module: dircc_packet_send_arbiter

---
 rtl/dircc_types_pkg.sv | 18 +
 rtl/dircc_rr_select.sv | 30 +++
 rtl/dircc_packet_send_arbiter.sv | 113 +++++++++++
 tb/tb_dircc_packet_send_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dircc_types_pkg.sv
// Shared packet types for the DIRCC packet path, plus the arbiter state encoding.
// The sender streams one packet_t as PACKET_WORDS words of WORD_BITS each.
package dircc_types_pkg;

    localparam int PACKET_WORDS = 8;
    localparam int WORD_BITS    = 32;

    typedef logic [15:0]                    address_t;
    typedef logic [WORD_BITS-1:0]           word_t;
    typedef word_t [PACKET_WORDS-1:0]       packet_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dircc_rr_select.sv
// Rotating-priority request selector.
// The search starts one index past i_last_grant and wraps around.
module dircc_rr_select #(
    parameter int NUM_REQUESTERS = 4
) (
    input  logic [NUM_REQUESTERS-1:0]         i_req,
    input  logic [$clog2(NUM_REQUESTERS)-1:0] i_last_grant,
    output logic [$clog2(NUM_REQUESTERS)-1:0] o_grant,
    output logic                              o_valid
);

    localparam int IW = $clog2(NUM_REQUESTERS);

    logic [IW-1:0] w_idx;

    // Scan from farthest to nearest so the nearest requester after i_last_grant is written last.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = NUM_REQUESTERS; k >= 1; k--) begin
            w_idx = IW'((int'(i_last_grant) + k) % NUM_REQUESTERS);
            if (i_req[w_idx]) begin
                o_grant = w_idx;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dircc_packet_send_arbiter.sv
// Round-robin arbiter that hands one requester's packet at a time to the packet sender.
// Its packet_data, write_packet and sending ports connect directly to the packet sender.
module dircc_packet_send_arbiter
    import dircc_types_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int ISSUE_TIMEOUT  = 64
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_REQUESTERS-1:0]       req_valid,
    input  packet_t [NUM_REQUESTERS-1:0]    req_packet,
    output logic [NUM_REQUESTERS-1:0]       req_accept,
    output logic [NUM_REQUESTERS-1:0]       req_done,
    output packet_t                         packet_data,
    output logic                            write_packet,
    input  logic                            sending,
    output logic                            timeout_err
);

    localparam int IW = $clog2(NUM_REQUESTERS);
    localparam int CW = $clog2(ISSUE_TIMEOUT + 1);

    arb_state_e                r_state;
    arb_state_e                w_next;
    logic [IW-1:0]             r_last_grant;
    logic [IW-1:0]             w_grant_idx;
    logic                      w_grant_valid;
    logic [CW-1:0]             r_count;
    logic                      w_grant_fire;
    logic                      w_done_fire;
    logic                      w_timeout_fire;
    logic [NUM_REQUESTERS-1:0] r_accept;
    logic [NUM_REQUESTERS-1:0] r_done;
    logic                      r_timeout;
    packet_t                   r_packet;

    dircc_rr_select #(
        .NUM_REQUESTERS(NUM_REQUESTERS)
    ) u_select (
        .i_req       (req_valid),
        .i_last_grant(r_last_grant),
        .o_grant     (w_grant_idx),
        .o_valid     (w_grant_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        w_grant_fire   = 1'b0;
        w_done_fire    = 1'b0;
        w_timeout_fire = 1'b0;
        case (r_state)
            IDLE: begin
                if (!sending && w_grant_valid) begin
                    w_grant_fire = 1'b1;
                    w_next       = ISSUE;
                end
            end
            ISSUE: begin
                if (sending) begin
                    w_next = BUSY;
                end else if (r_count == CW'(ISSUE_TIMEOUT - 1)) begin
                    w_timeout_fire = 1'b1;
                    w_next         = IDLE;
                end
            end
            BUSY: begin
                if (!sending) begin
                    w_done_fire = 1'b1;
                    w_next      = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // The counter saturates rather than wrapping; the ISSUE exit normally stops it first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= IW'(NUM_REQUESTERS - 1);
            r_count      <= '0;
            r_accept     <= '0;
            r_done       <= '0;
            r_timeout    <= 1'b0;
            r_packet     <= '0;
        end else begin
            r_accept  <= '0;
            r_done    <= '0;
            r_timeout <= w_timeout_fire;
            if (w_grant_fire) begin
                r_last_grant <= w_grant_idx;
                r_packet     <= req_packet[w_grant_idx];
                r_accept     <= (NUM_REQUESTERS)'(1) << w_grant_idx;
                r_count      <= '0;
            end else if (r_state == ISSUE && r_count != '1) begin
                r_count <= r_count + CW'(1);
            end
            if (w_done_fire) r_done <= (NUM_REQUESTERS)'(1) << r_last_grant;
        end
    end

    assign write_packet = (r_state == ISSUE);
    assign req_accept   = r_accept;
    assign req_done     = r_done;
    assign timeout_err  = r_timeout;
    assign packet_data  = r_packet;

endmodule

// File: tb/tb_dircc_packet_send_arbiter.sv
// Directed bench for dircc_packet_send_arbiter: single transfer, fairness, timeout,
// sender-busy hold-off and reset in the middle of a transfer.
module tb_dircc_packet_send_arbiter;
    import dircc_types_pkg::*;

    localparam int N  = 4;
    localparam int TO = 16;

    logic             clk;
    logic             reset_n;
    logic [N-1:0]     req_valid;
    packet_t [N-1:0]  req_packet;
    logic [N-1:0]     req_accept;
    logic [N-1:0]     req_done;
    packet_t          packet_data;
    logic             write_packet;
    logic             sending;
    logic             timeout_err;

    packet_t          expPkt [N];
    int               assertCount;
    int               failCount;

    dircc_packet_send_arbiter #(
        .NUM_REQUESTERS(N),
        .ISSUE_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_packet  (req_packet),
        .req_accept  (req_accept),
        .req_done    (req_done),
        .packet_data (packet_data),
        .write_packet(write_packet),
        .sending     (sending),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge so outputs have settled.
    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyReset();
        reset_n   = 1'b0;
        req_valid = '0;
        sending   = 1'b0;
        waitCycle();
        waitCycle();
        reset_n = 1'b1;
    endtask

    // Wait for an accept, act as the sender for an 8-cycle packet and check the done pulse.
    task automatic serveOne(input int expIdx, input bit dropValid);
        int n;
        n = 0;
        while (req_accept == '0 && n < 10) begin
            waitCycle();
            n++;
        end
        checkOutput($sformatf("accept_idx%0d", expIdx), 256'(req_accept), 256'(4'b0001 << expIdx));
        checkOutput("write_at_accept", 256'(write_packet), 256'(1'b1));
        checkOutput($sformatf("packet_idx%0d", expIdx), packet_data, expPkt[expIdx]);
        if (dropValid) req_valid[expIdx] = 1'b0;
        sending = 1'b1;
        waitCycle();
        checkOutput("write_dropped", 256'(write_packet), 256'(1'b0));
        repeat (7) waitCycle();
        sending = 1'b0;
        waitCycle();
        checkOutput($sformatf("done_idx%0d", expIdx), 256'(req_done), 256'(4'b0001 << expIdx));
    endtask

    initial begin
        int wCount;
        int tCount;
        int dCount;
        int badAccept;
        assertCount = 0;
        failCount   = 0;
        for (int i = 0; i < N; i++) begin
            for (int w = 0; w < PACKET_WORDS; w++) begin
                expPkt[i][w] = 32'hA000_0000 | (i << 12) | (w * 17 + 3);
            end
            req_packet[i] = expPkt[i];
        end

        // Reset state
        applyReset();
        reset_n = 1'b0;
        #1;
        checkOutput("rst_accept", 256'(req_accept), 256'(0));
        checkOutput("rst_done", 256'(req_done), 256'(0));
        checkOutput("rst_write", 256'(write_packet), 256'(0));
        checkOutput("rst_timeout", 256'(timeout_err), 256'(0));
        checkOutput("rst_packet", packet_data, 256'(0));
        waitCycle();
        reset_n = 1'b1;

        // Single request to index 2; sender responds after 3 cycles of write_packet
        req_valid = 4'b0100;
        waitCycle();
        checkOutput("single_accept", 256'(req_accept), 256'(4'b0100));
        checkOutput("single_packet", packet_data, expPkt[2]);
        req_valid     = 4'b0000;
        req_packet[2] = '1;
        wCount = 0;
        for (int c = 0; c < 3; c++) begin
            if (write_packet) wCount++;
            if (c == 2) sending = 1'b1;
            waitCycle();
        end
        checkOutput("single_write_cycles", 256'(wCount), 256'(3));
        checkOutput("single_write_low", 256'(write_packet), 256'(0));
        dCount = 0;
        for (int c = 0; c < 7; c++) begin
            if (req_done != '0) dCount++;
            waitCycle();
        end
        checkOutput("single_no_early_done", 256'(dCount), 256'(0));
        sending = 1'b0;
        waitCycle();
        checkOutput("single_done", 256'(req_done), 256'(4'b0100));
        checkOutput("single_packet_held", packet_data, expPkt[2]);
        waitCycle();
        checkOutput("single_done_pulse", 256'(req_done), 256'(0));
        req_packet[2] = expPkt[2];

        // Fairness: all requesters held high for 8 packets
        applyReset();
        req_valid = 4'b1111;
        for (int p = 0; p < 8; p++) serveOne(p % N, 1'b0);
        req_valid = 4'b0000;
        waitCycle();

        // Timeout: sender never responds
        applyReset();
        req_valid = 4'b0001;
        waitCycle();
        checkOutput("to_accept", 256'(req_accept), 256'(4'b0001));
        req_valid = 4'b0000;
        wCount = 0;
        tCount = 0;
        dCount = 0;
        for (int c = 0; c < 30; c++) begin
            if (write_packet) wCount++;
            if (timeout_err) tCount++;
            if (req_done != '0) dCount++;
            waitCycle();
        end
        checkOutput("to_write_cycles", 256'(wCount), 256'(TO));
        checkOutput("to_err_pulses", 256'(tCount), 256'(1));
        checkOutput("to_no_done", 256'(dCount), 256'(0));
        req_valid = 4'b0010;
        serveOne(1, 1'b1);

        // Sender busy before any request: no grant until sending falls
        applyReset();
        sending   = 1'b1;
        req_valid = 4'b0001;
        badAccept = 0;
        for (int c = 0; c < 5; c++) begin
            waitCycle();
            if (req_accept != '0) badAccept++;
        end
        checkOutput("busy_no_accept", 256'(badAccept), 256'(0));
        sending = 1'b0;
        waitCycle();
        checkOutput("busy_grant_next_edge", 256'(req_accept), 256'(4'b0001));
        serveOne(0, 1'b1);

        // Reset in the middle of BUSY
        req_valid = 4'b0100;
        waitCycle();
        checkOutput("mid_accept", 256'(req_accept), 256'(4'b0100));
        req_valid = 4'b0000;
        sending   = 1'b1;
        repeat (3) waitCycle();
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_write", 256'(write_packet), 256'(0));
        checkOutput("mid_rst_accept", 256'(req_accept), 256'(0));
        checkOutput("mid_rst_done", 256'(req_done), 256'(0));
        checkOutput("mid_rst_timeout", 256'(timeout_err), 256'(0));
        checkOutput("mid_rst_packet", packet_data, 256'(0));
        sending = 1'b0;
        waitCycle();
        reset_n = 1'b1;
        dCount = 0;
        for (int c = 0; c < 3; c++) begin
            waitCycle();
            if (req_done != '0 || timeout_err) dCount++;
        end
        checkOutput("mid_no_pulses", 256'(dCount), 256'(0));
        req_valid = 4'b1000;
        serveOne(3, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
